light_controller: RTL and testbench
===================================

LIGHT_CONTROLLER -- requirements
Module: light_controller

Interface
REQ-001 SHALL have port clk  input  1  system clock, 1 Hz tick domain, all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-003 SHALL have port counter_value  input  6  remaining-seconds value returned by the downstream counter.
REQ-004 SHALL have port ped_req  input  1  pedestrian request, level, sampled each cycle.
REQ-005 SHALL have port night_mode  input  1  night flashing request, level.
REQ-006 SHALL have port timer_value  output  6  phase duration driven to the downstream counter.
REQ-007 SHALL have ports red, yellow, green  output  1 each  lamp drives.
REQ-008 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-009 SHALL have port phase  output  2  current state encoding: RED=0, GREEN=1, YELLOW=2, FLASH=3.
REQ-010 SHALL use parameters T_RED default 18, T_GREEN default 15, T_YELLOW default 3, T_FLASH default 1; all 6-bit, range 1..63.

Function
REQ-011 SHALL implement states RED, GREEN, YELLOW, FLASH; the state register is the only source of phase.
REQ-012 SHALL drive timer_value combinationally from state: RED->T_RED, GREEN->T_GREEN, YELLOW->T_YELLOW, FLASH->T_FLASH.
REQ-013 SHALL keep an internal armed flag: cleared on every state change, set on the first cycle counter_value != 0.
REQ-014 SHALL define expiry = armed AND counter_value == 0; only expiry causes a state transition.
REQ-015 SHALL transition on expiry: RED->GREEN, GREEN->YELLOW, YELLOW->RED, with the next state registered on that edge (one-cycle latency).
REQ-016 SHALL, on expiry in any of RED/GREEN/YELLOW while night_mode=1, go to FLASH instead of the normal successor.
REQ-017 SHALL, in FLASH, toggle an internal flash bit on each expiry; yellow = flash bit, red = green = walk = 0.
REQ-018 SHALL, on expiry in FLASH with night_mode=0, go to RED with flash bit cleared; with night_mode=1, remain in FLASH.
REQ-019 SHALL drive lamps one-hot outside FLASH: red in RED, green in GREEN, yellow in YELLOW.
REQ-020 SHALL latch ped_req=1 into ped_pend in any state other than FLASH; ped_req in FLASH is ignored.
REQ-021 SHALL assert walk in RED only if ped_pend was set on entry to RED or becomes set during RED; walk remains asserted until RED exits.
REQ-022 SHALL clear ped_pend on the edge leaving RED; ped_req high on that same edge re-latches it (set wins).
REQ-023 SHALL ignore counter_value == 0 while unarmed, so a stale zero after a state change never causes a double advance.
REQ-024 SHALL stay in state indefinitely if counter_value never reaches 0; no internal timeout.

Reset
REQ-025 SHALL, on reset=0 at a rising edge, set state=RED, timer_value=T_RED, red=1, yellow=green=walk=0, phase=0, armed=0, ped_pend=0, flash bit=0.
REQ-026 SHALL let reset asserted mid-phase, including FLASH, override every other input on that edge.

Structure
REQ-027 SHALL take state encoding and default durations from shared package light_pkg, which the counter side also uses.
REQ-028 SHALL place armed/expiry detection in one sub-module light_expiry (inputs clk, reset, counter_value, state_change; output expiry).

Verification
REQ-029 Reset low 1 cycle, then counter counting 18..0 -> phase=0, red=1, timer_value=18 until expiry; next edge phase=1, timer_value=15.
REQ-030 Full cycle 18/15/3 with night_mode=0 -> sequence RED, GREEN, YELLOW, RED; exactly one advance per zero; held counter_value=0 for 3 cycles after change -> no extra advance.
REQ-031 ped_req pulse 1 cycle during GREEN -> walk=1 throughout the next RED, 0 in the following GREEN.
REQ-032 night_mode=1 raised mid-GREEN -> FLASH at GREEN expiry; timer_value=1, yellow toggles each expiry; night_mode=0 -> RED at next expiry.
REQ-033 reset=0 asserted in YELLOW with counter_value=2 -> next edge RED, timer_value=18, walk=0, ped_pend cleared.
REQ-034 ped_req=1 held on the RED->GREEN edge -> ped_pend remains 1 and walk=1 in the next RED.

Source files
------------

// File: rtl/light_pkg.sv
// Shared definitions for the traffic light controller and its downstream counter:
// phase encoding and default phase durations in seconds.
package light_pkg;

    localparam int TIMER_W = 6;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } light_state_t;

    localparam logic [TIMER_W-1:0] T_RED_DEFAULT    = 6'd18;
    localparam logic [TIMER_W-1:0] T_GREEN_DEFAULT  = 6'd15;
    localparam logic [TIMER_W-1:0] T_YELLOW_DEFAULT = 6'd3;
    localparam logic [TIMER_W-1:0] T_FLASH_DEFAULT  = 6'd1;

endpackage

// File: rtl/light_expiry.sv
// Expiry detector: a phase may only end once the counter has been seen non-zero,
// so a stale zero left over from the previous phase never advances the FSM twice.
module light_expiry
    import light_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [TIMER_W-1:0] counter_value,
    input  logic               state_change,
    output logic               expiry
);

    logic armed_reg;
    logic armed_next;

    always_comb begin
        armed_next = armed_reg;
        if (state_change) begin
            armed_next = 1'b0;
        end else if (counter_value != '0) begin
            armed_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= armed_next;
        end
    end

    assign expiry = armed_reg && (counter_value == '0);

endmodule

// File: rtl/light_controller.sv
// Traffic light phase sequencer with pedestrian walk request and night flashing mode.
// Phase durations are handed to an external down-counter whose zero ends the phase.
module light_controller
    import light_pkg::*;
#(
    parameter logic [5:0] T_RED    = T_RED_DEFAULT,
    parameter logic [5:0] T_GREEN  = T_GREEN_DEFAULT,
    parameter logic [5:0] T_YELLOW = T_YELLOW_DEFAULT,
    parameter logic [5:0] T_FLASH  = T_FLASH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] counter_value,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [5:0] timer_value,
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic       walk,
    output logic [1:0] phase
);

    light_state_t state_reg, state_next;
    logic         flash_reg, flash_next;
    logic         ped_pend_reg, ped_pend_next;
    logic         expiry;

    // Every expiry is treated as a phase (re)entry, including FLASH staying in
    // FLASH, so the reloaded counter must be seen non-zero before the next toggle.
    light_expiry u_expiry (
        .clk           (clk),
        .reset         (reset),
        .counter_value (counter_value),
        .state_change  (expiry),
        .expiry        (expiry)
    );

    always_comb begin
        state_next    = state_reg;
        flash_next    = flash_reg;
        ped_pend_next = ped_pend_reg;

        if (expiry) begin
            unique case (state_reg)
                ST_RED:    state_next = night_mode ? ST_FLASH : ST_GREEN;
                ST_GREEN:  state_next = night_mode ? ST_FLASH : ST_YELLOW;
                ST_YELLOW: state_next = night_mode ? ST_FLASH : ST_RED;
                ST_FLASH:  state_next = night_mode ? ST_FLASH : ST_RED;
            endcase
        end

        if (state_reg != ST_FLASH) begin
            flash_next = 1'b0;
        end else if (expiry) begin
            flash_next = night_mode ? ~flash_reg : 1'b0;
        end

        // A request arriving on the same edge that leaves RED must survive.
        if (state_reg == ST_RED && expiry) begin
            ped_pend_next = 1'b0;
        end
        if (ped_req && state_reg != ST_FLASH) begin
            ped_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_RED;
            flash_reg    <= 1'b0;
            ped_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            flash_reg    <= flash_next;
            ped_pend_reg <= ped_pend_next;
        end
    end

    always_comb begin
        timer_value = T_RED;
        unique case (state_reg)
            ST_RED:    timer_value = T_RED;
            ST_GREEN:  timer_value = T_GREEN;
            ST_YELLOW: timer_value = T_YELLOW;
            ST_FLASH:  timer_value = T_FLASH;
        endcase
    end

    assign phase  = state_reg;
    assign red    = (state_reg == ST_RED);
    assign green  = (state_reg == ST_GREEN);
    assign yellow = (state_reg == ST_FLASH) ? flash_reg : (state_reg == ST_YELLOW);
    assign walk   = (state_reg == ST_RED) && ped_pend_reg;

endmodule

// File: tb/tb_light_controller.sv
// Directed bench for light_controller: the bench plays the downstream counter and
// checks lamps, phase and duration after every edge against a scoreboard queue.
module tb_light_controller;

    localparam logic [1:0] P_RED    = 2'd0;
    localparam logic [1:0] P_GREEN  = 2'd1;
    localparam logic [1:0] P_YELLOW = 2'd2;
    localparam logic [1:0] P_FLASH  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] counter_value;
    logic       ped_req;
    logic       night_mode;
    logic [5:0] timer_value;
    logic       red, yellow, green, walk;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    // {phase, timer_value, red, yellow, green, walk}
    logic [11:0] sb_q[$];

    light_controller dut (
        .clk           (clk),
        .reset         (reset),
        .counter_value (counter_value),
        .ped_req       (ped_req),
        .night_mode    (night_mode),
        .timer_value   (timer_value),
        .red           (red),
        .yellow        (yellow),
        .green         (green),
        .walk          (walk),
        .phase         (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] dur(input logic [1:0] ph);
        case (ph)
            P_RED:    return 6'd18;
            P_GREEN:  return 6'd15;
            P_YELLOW: return 6'd3;
            default:  return 6'd1;
        endcase
    endfunction

    // Drive one cycle of inputs, push the expected post-edge outputs, then compare.
    task automatic step(input logic rst, input logic [5:0] cv, input logic p, input logic n,
                        input logic [1:0] ph, input logic w, input logic fy, input string tag);
        logic [11:0] exp_v;
        logic [11:0] got_v;
        logic        y_exp;
        reset         = rst;
        counter_value = cv;
        ped_req       = p;
        night_mode    = n;
        y_exp = (ph == P_FLASH) ? fy : (ph == P_YELLOW);
        sb_q.push_back({ph, dur(ph), ph == P_RED, y_exp, ph == P_GREEN, w});
        @(posedge clk);
        #1;
        got_v = {phase, timer_value, red, yellow, green, walk};
        exp_v = sb_q.pop_front();
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s cv=%0d: got ph=%0d t=%0d ryg=%b%b%b w=%b, expected ph=%0d t=%0d ryg=%b%b%b w=%b",
                   tag, cv, got_v[11:10], got_v[9:4], got_v[3], got_v[2], got_v[1], got_v[0],
                   exp_v[11:10], exp_v[9:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Counter runs from..1 in phase ph; ped pulses at ped_at, night goes high at night_from.
    task automatic count(input int from, input logic [1:0] ph, input logic w,
                         input int ped_at, input int night_from, input string tag);
        for (int v = from; v >= 1; v--) begin
            logic [5:0] cv;
            cv = v[5:0];
            step(1'b1, cv, v == ped_at, (night_from > 0) && (v <= night_from), ph, w, 1'b0, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then first RED phase and the advance to GREEN.
        step(1'b0, 6'd0, 1'b0, 1'b0, P_RED, 1'b0, 1'b0, "reset");
        count(18, P_RED, 1'b0, 0, 0, "red1");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_GREEN, 1'b0, 1'b0, "red1_exp");

        // Stale zeros after each change must not advance; ped pulse mid-GREEN.
        for (int i = 0; i < 3; i++) step(1'b1, 6'd0, 1'b0, 1'b0, P_GREEN, 1'b0, 1'b0, "stale_g");
        count(15, P_GREEN, 1'b0, 10, 0, "green_ped");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_YELLOW, 1'b0, 1'b0, "green_exp");
        for (int i = 0; i < 3; i++) step(1'b1, 6'd0, 1'b0, 1'b0, P_YELLOW, 1'b0, 1'b0, "stale_y");
        count(3, P_YELLOW, 1'b0, 0, 0, "yellow");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_RED, 1'b1, 1'b0, "yellow_exp_walk");
        count(18, P_RED, 1'b1, 0, 0, "red_walk");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_GREEN, 1'b0, 1'b0, "walk_clears");

        // Request held on the RED->GREEN edge re-latches.
        count(15, P_GREEN, 1'b0, 0, 0, "green2");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_YELLOW, 1'b0, 1'b0, "green2_exp");
        count(3, P_YELLOW, 1'b0, 0, 0, "yellow2");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_RED, 1'b0, 1'b0, "red2_nowalk");
        count(18, P_RED, 1'b0, 0, 0, "red2");
        step(1'b1, 6'd0, 1'b1, 1'b0, P_GREEN, 1'b0, 1'b0, "ped_on_exit");
        count(15, P_GREEN, 1'b0, 0, 0, "green3");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_YELLOW, 1'b0, 1'b0, "green3_exp");
        count(3, P_YELLOW, 1'b0, 0, 0, "yellow3");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_RED, 1'b1, 1'b0, "relatched_walk");
        count(18, P_RED, 1'b1, 0, 0, "red3_walk");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_GREEN, 1'b0, 1'b0, "red3_exp");

        // Night mode raised mid-GREEN; ped requests in FLASH are ignored.
        count(15, P_GREEN, 1'b0, 0, 8, "green_night");
        step(1'b1, 6'd0, 1'b0, 1'b1, P_FLASH, 1'b0, 1'b0, "enter_flash");
        step(1'b1, 6'd1, 1'b1, 1'b1, P_FLASH, 1'b0, 1'b0, "flash_a1");
        step(1'b1, 6'd0, 1'b1, 1'b1, P_FLASH, 1'b0, 1'b1, "flash_t1");
        step(1'b1, 6'd1, 1'b1, 1'b1, P_FLASH, 1'b0, 1'b1, "flash_a2");
        step(1'b1, 6'd0, 1'b0, 1'b1, P_FLASH, 1'b0, 1'b0, "flash_t2");
        step(1'b1, 6'd1, 1'b1, 1'b1, P_FLASH, 1'b0, 1'b0, "flash_a3");
        step(1'b1, 6'd0, 1'b0, 1'b1, P_FLASH, 1'b0, 1'b1, "flash_t3");
        step(1'b1, 6'd1, 1'b0, 1'b0, P_FLASH, 1'b0, 1'b1, "flash_day");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_RED, 1'b0, 1'b0, "flash_exit");

        // Reset mid-YELLOW with a pending request, then a stale zero after reset.
        count(18, P_RED, 1'b0, 0, 0, "red4");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_GREEN, 1'b0, 1'b0, "red4_exp");
        count(15, P_GREEN, 1'b0, 0, 0, "green4");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_YELLOW, 1'b0, 1'b0, "green4_exp");
        step(1'b1, 6'd3, 1'b1, 1'b0, P_YELLOW, 1'b0, 1'b0, "yellow_ped");
        step(1'b0, 6'd2, 1'b0, 1'b0, P_RED, 1'b0, 1'b0, "reset_in_yellow");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_RED, 1'b0, 1'b0, "stale_after_reset");
        count(18, P_RED, 1'b0, 0, 0, "red_after_reset");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_GREEN, 1'b0, 1'b0, "red5_exp");

        // Reset while flashing overrides night_mode.
        count(15, P_GREEN, 1'b0, 0, 15, "green_night2");
        step(1'b1, 6'd0, 1'b0, 1'b1, P_FLASH, 1'b0, 1'b0, "enter_flash2");
        step(1'b1, 6'd1, 1'b0, 1'b1, P_FLASH, 1'b0, 1'b0, "flash2_a");
        step(1'b0, 6'd0, 1'b1, 1'b1, P_RED, 1'b0, 1'b0, "reset_in_flash");
        step(1'b1, 6'd0, 1'b0, 1'b0, P_RED, 1'b0, 1'b0, "stale_after_reset2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
